// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, write-port struct and busy-count delta helper
package regfile_pkg;

  localparam int D_WIDTH_DEF    = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NRD_MAX        = 4;

  typedef struct packed {
    logic                      we;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [D_WIDTH_DEF-1:0]    data;
  } wr_port_t;

  // Net change of the busy population: +1 for a newly set register,
  // -1 for each distinct busy register actually released this cycle.
  function automatic logic [2:0] busy_delta(input logic set_new,
                                            input logic rel0,
                                            input logic rel1);
    return {2'b00, set_new} - {2'b00, rel0} - {2'b00, rel1};
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read, write, issue and status bundle of the register file
interface regfile_sb_if #(
  parameter int D_WIDTH    = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NRD        = 2
);
  logic [NRD*ADDR_WIDTH-1:0] raddr;
  logic [NRD*D_WIDTH-1:0]    rdata;
  logic [NRD-1:0]            rbusy;
  logic                      we0;
  logic [ADDR_WIDTH-1:0]     waddr0;
  logic [D_WIDTH-1:0]        wdata0;
  logic                      we1;
  logic [ADDR_WIDTH-1:0]     waddr1;
  logic [D_WIDTH-1:0]        wdata1;
  logic                      iss_valid;
  logic [ADDR_WIDTH-1:0]     iss_addr;
  logic                      iss_stall;
  logic [ADDR_WIDTH:0]       busy_cnt;

  modport master (
    output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, iss_valid, iss_addr,
    input  rdata, rbusy, iss_stall, busy_cnt
  );

  modport slave (
    input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, iss_valid, iss_addr,
    output rdata, rbusy, iss_stall, busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits, busy count and WAW issue stall
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] waddr0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] waddr1,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  output logic [DEPTH-1:0]      busy,
  output logic                  iss_stall,
  output logic [ADDR_WIDTH:0]   busy_cnt
);

  logic             clr0, clr1, iss_clr, set_ok;
  logic             rel0, rel1, set_new;
  logic [2:0]       delta;
  logic [DEPTH-1:0] busy_next;

  assign clr0    = we0 && (waddr0 != '0);
  assign clr1    = we1 && (waddr1 != '0);
  assign iss_clr = (clr0 && (waddr0 == iss_addr)) || (clr1 && (waddr1 == iss_addr));

  assign iss_stall = iss_valid && (iss_addr != '0) && busy[iss_addr] && !iss_clr;
  assign set_ok    = iss_valid && !iss_stall && (iss_addr != '0);

  // Only count registers that really flip; a set on a cleared register nets to zero
  // and two ports hitting one register release it once.
  assign rel0    = clr0 && busy[waddr0] && !(set_ok && (iss_addr == waddr0));
  assign rel1    = clr1 && busy[waddr1] && !(set_ok && (iss_addr == waddr1))
                   && !(clr0 && (waddr0 == waddr1));
  assign set_new = set_ok && !busy[iss_addr];
  assign delta   = busy_delta(set_new, rel0, rel1);

  // Next busy vector: clears first, then the issue set so a same-cycle set wins.
  always_comb begin
    busy_next = busy;
    if (clr0)   busy_next[waddr0]   = 1'b0;
    if (clr1)   busy_next[waddr1]   = 1'b0;
    if (set_ok) busy_next[iss_addr] = 1'b1;
  end

  // Busy vector and its running population count update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= busy_cnt + {{(ADDR_WIDTH-2){delta[2]}}, delta};
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with scoreboard; REGFILE_BYPASS_EN enables write-to-read bypass
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int D_WIDTH    = D_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NRD        = 2,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   busy;

  regfile_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .we0       (bus.we0),
    .waddr0    (bus.waddr0),
    .we1       (bus.we1),
    .waddr1    (bus.waddr1),
    .iss_valid (bus.iss_valid),
    .iss_addr  (bus.iss_addr),
    .busy      (busy),
    .iss_stall (bus.iss_stall),
    .busy_cnt  (bus.busy_cnt)
  );

  // Storage: port 1 is written last so it wins an address clash; R0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (bus.we0 && (bus.waddr0 != '0)) mem[bus.waddr0] <= bus.wdata0;
      if (bus.we1 && (bus.waddr1 != '0)) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [D_WIDTH-1:0]    d;
    logic                  b;

    assign a = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    // Read mux with optional same-cycle bypass; R0 and reset force zero.
    always_comb begin
      d = mem[a];
      b = busy[a];
`ifdef REGFILE_BYPASS_EN
      if (bus.we1 && (bus.waddr1 == a)) begin
        d = bus.wdata1;
        b = bus.iss_valid && (bus.iss_addr == a);
      end else if (bus.we0 && (bus.waddr0 == a)) begin
        d = bus.wdata0;
        b = bus.iss_valid && (bus.iss_addr == a);
      end
`endif
      if ((a == '0) || !rst_n) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign bus.rdata[i*D_WIDTH +: D_WIDTH] = d;
    assign bus.rbusy[i]                    = b;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed and random checks of regfile_sb against a reference model
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_mem [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_sb_if #(.D_WIDTH(32), .ADDR_WIDTH(5), .NRD(2)) bus ();

  regfile_sb #(.D_WIDTH(32), .ADDR_WIDTH(5), .NRD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wr_port_t wp(input logic we, input logic [4:0] a, input logic [31:0] d);
    wr_port_t p;
    p.we = we; p.addr = a; p.data = d;
    return p;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < 32; k++) n += int'(m_busy[k]);
    return n;
  endfunction

  function automatic bit m_hit(input logic [4:0] a);
    return a != 0 && ((bus.we0 && bus.waddr0 == a) || (bus.we1 && bus.waddr1 == a));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin m_mem[k] = '0; m_busy[k] = 1'b0; end
  endtask

  task automatic drive(input wr_port_t p0, input wr_port_t p1, input logic iv,
                       input logic [4:0] ia, input logic [4:0] r0, input logic [4:0] r1);
    bus.we0 = p0.we; bus.waddr0 = p0.addr; bus.wdata0 = p0.data;
    bus.we1 = p1.we; bus.waddr1 = p1.addr; bus.wdata1 = p1.data;
    bus.iss_valid = iv; bus.iss_addr = ia;
    bus.raddr = {r1, r0};
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(wp(0, 0, 0), wp(0, 0, 0), 1'b0, 5'd0, r0, r1);
  endtask

  // Let combinational outputs settle, then compare them with the model.
  task automatic settle();
    logic [4:0]  a;
    logic [31:0] ed;
    logic        eb;
    #1;
    for (int i = 0; i < 2; i++) begin
      a  = bus.raddr[i*5 +: 5];
      ed = m_mem[a];
      eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (bus.we1 && bus.waddr1 == a) begin
        ed = bus.wdata1; eb = bus.iss_valid && bus.iss_addr == a;
      end else if (bus.we0 && bus.waddr0 == a) begin
        ed = bus.wdata0; eb = bus.iss_valid && bus.iss_addr == a;
      end
`endif
      if (a == 0) begin ed = 0; eb = 0; end
      chk($sformatf("rdata%0d", i), bus.rdata[i*32 +: 32], ed);
      chk($sformatf("rbusy%0d", i), {31'd0, bus.rbusy[i]}, {31'd0, eb});
    end
    chk("iss_stall", {31'd0, bus.iss_stall},
        {31'd0, bus.iss_valid && bus.iss_addr != 0 && m_busy[bus.iss_addr] && !m_hit(bus.iss_addr)});
  endtask

  // Advance one clock, apply the specification rules to the model, check the count.
  task automatic clock();
    logic [31:0] nmem [32];
    bit          nbusy [32];
    bit          stall;
    nmem = m_mem; nbusy = m_busy;
    stall = bus.iss_valid && bus.iss_addr != 0 && m_busy[bus.iss_addr] && !m_hit(bus.iss_addr);
    if (bus.we0 && bus.waddr0 != 0) begin nmem[bus.waddr0] = bus.wdata0; nbusy[bus.waddr0] = 0; end
    if (bus.we1 && bus.waddr1 != 0) begin nmem[bus.waddr1] = bus.wdata1; nbusy[bus.waddr1] = 0; end
    if (bus.iss_valid && !stall && bus.iss_addr != 0) nbusy[bus.iss_addr] = 1;
    @(posedge clk);
    #1;
    m_mem = nmem; m_busy = nbusy;
    chk("busy_cnt", 32'(bus.busy_cnt), 32'(m_count()));
  endtask

  task automatic step();
    settle();
    clock();
  endtask

  initial begin
    model_reset();
    idle(5'd0, 5'd0);
    #12;
    chk("rst_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("rst_rdata", bus.rdata[31:0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. async reset drops stored data and busy state
    drive(wp(1, 5, 32'h1234), wp(0, 0, 0), 1'b1, 5'd4, 5'd5, 5'd4);
    step();
    idle(5'd5, 5'd4);
    settle();
    chk("r5_written", bus.rdata[31:0], 32'h1234);
    chk("cnt_before_rst", 32'(bus.busy_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_r5", bus.rdata[31:0], 32'd0);
    chk("rst_cnt_async", 32'(bus.busy_cnt), 32'd0);
    chk("rst_rbusy", 32'(bus.rbusy), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;

    // 2. R0 writes and issues are dropped
    drive(wp(1, 0, 32'hFFFF_FFFF), wp(0, 0, 0), 1'b1, 5'd0, 5'd0, 5'd0);
    step();
    idle(5'd0, 5'd0);
    settle();
    chk("r0_data", bus.rdata[31:0], 32'd0);
    chk("r0_cnt", 32'(bus.busy_cnt), 32'd0);

    // 3. scoreboard set, WAW stall, write releasing the stall
    drive(wp(0, 0, 0), wp(0, 0, 0), 1'b1, 5'd3, 5'd3, 5'd0);
    step();
    chk("r3_busy", {31'd0, bus.rbusy[0]}, 32'd1);
    drive(wp(0, 0, 0), wp(0, 0, 0), 1'b1, 5'd3, 5'd3, 5'd0);
    settle();
    chk("waw_stall", {31'd0, bus.iss_stall}, 32'd1);
    clock();
    drive(wp(0, 0, 0), wp(1, 3, 32'hAB), 1'b1, 5'd3, 5'd3, 5'd3);
    settle();
    chk("waw_release", {31'd0, bus.iss_stall}, 32'd0);
    clock();
    chk("r3_still_cnt", 32'(bus.busy_cnt), 32'd1);
    idle(5'd3, 5'd0);
    settle();
    chk("r3_still_busy", {31'd0, bus.rbusy[0]}, 32'd1);
    chk("r3_data", bus.rdata[31:0], 32'hAB);

    // 4. dual-write conflict and double release
    drive(wp(1, 7, 32'h11), wp(1, 7, 32'h22), 1'b1, 5'd10, 5'd0, 5'd0);
    step();
    drive(wp(0, 0, 0), wp(0, 0, 0), 1'b1, 5'd11, 5'd7, 5'd0);
    settle();
    chk("r7_port1_wins", bus.rdata[31:0], 32'h22);
    clock();
    chk("cnt3", 32'(bus.busy_cnt), 32'd3);
    drive(wp(1, 10, 32'h1), wp(1, 11, 32'h2), 1'b0, 5'd0, 5'd10, 5'd11);
    step();
    chk("cnt_minus2", 32'(bus.busy_cnt), 32'd1);

    // 5. bypass behaviour
    drive(wp(1, 9, 32'h5), wp(0, 0, 0), 1'b0, 5'd0, 5'd0, 5'd0);
    step();
    drive(wp(1, 9, 32'h77), wp(0, 0, 0), 1'b0, 5'd0, 5'd0, 5'd9);
    settle();
`ifdef REGFILE_BYPASS_EN
    chk("bypass_r9", bus.rdata[63:32], 32'h77);
`else
    chk("bypass_r9", bus.rdata[63:32], 32'h5);
`endif
    clock();
    idle(5'd0, 5'd9);
    settle();
    chk("r9_next", bus.rdata[63:32], 32'h77);

    // 6. fill all registers, then drain
    drive(wp(1, 3, 32'h0), wp(0, 0, 0), 1'b0, 5'd0, 5'd0, 5'd0);
    step();
    for (int r = 1; r < 32; r++) begin
      drive(wp(0, 0, 0), wp(0, 0, 0), 1'b1, 5'(r), 5'(r), 5'(r - 1));
      step();
    end
    chk("fill_cnt", 32'(bus.busy_cnt), 32'd31);
    for (int r = 1; r < 32; r += 2) begin
      drive(wp(1, 5'(r), 32'(r)), wp(r < 31, 5'(r + 1), 32'(r + 1)), 1'b0, 5'd0, 5'(r), 5'(r + 1));
      step();
    end
    chk("drain_cnt", 32'(bus.busy_cnt), 32'd0);

    // random traffic on a small address window to force collisions
    for (int n = 0; n < 400; n++) begin
      drive(wp($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom),
            wp($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
